// File: rtl/mips_debug_pkg.sv
// Shared definitions for the debug-port instruction loader.
// State set depends on LOADER_CHECKSUM_EN (adds the checksum state).
package mips_debug_pkg;

    localparam int DEF_IMEM_ADDR_W = 8;

    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP_MODE = 8'h53;  // 'S'
    localparam logic [7:0] CMD_STEP = 8'h4E;  // 'N'

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA
`ifdef LOADER_CHECKSUM_EN
        , ST_CHK
`endif
    } state_t;

endpackage

// File: rtl/interface_loader_word_assembler.sv
// Packs received bytes MSB first into 32-bit words; word_done marks the 4th byte.
// word/word_done are valid in the same cycle as the 4th byte so the top can register them.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [23:0] shift;
    logic [1:0]  byte_cnt;

    // Shift register and byte counter; clear drops any partial word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift    <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            shift    <= {shift[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Completed word is the three held bytes plus the current one.
    always_comb begin
        word      = {shift, byte_in};
        word_done = byte_valid && (byte_cnt == 2'd3);
    end

endmodule

// File: rtl/interface_loader.sv
// UART-driven instruction loader and execution-mode control.
// Optional: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
//
// state     | meaning
// ST_IDLE   | decode command bytes
// ST_CNT_HI | waiting for word-count MSB
// ST_CNT_LO | waiting for word-count LSB
// ST_DATA   | receiving instruction bytes
// ST_CHK    | waiting for checksum byte (LOADER_CHECKSUM_EN only)
module interface_loader
    import mips_debug_pkg::*;
#(
    parameter int IMEM_ADDR_W    = DEF_IMEM_ADDR_W,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_done,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_data,
    output logic                   o_exec_mode,
    output logic                   o_step,
    output logic                   o_busy,
    output logic                   o_load_done,
    output logic                   o_error
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] WORD_LIMIT = 32'(64'(1) << IMEM_ADDR_W);

    state_t state, state_next;

    logic [7:0]             cnt_hi;
    logic [15:0]            words_left;
    logic [IMEM_ADDR_W-1:0] wr_idx;
    logic [TW-1:0]          tmo_cnt;
    logic                   timeout;

    logic        load_start, load_ok, load_fail;
    logic        set_mode, mode_val, step_req, bad_cmd, cnt_capture;
    logic [15:0] count_n;

    logic        asm_valid, asm_clear, word_done;
    logic [31:0] word;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_acc;
`endif

    assign count_n   = {cnt_hi, i_rx_data};
    assign asm_valid = i_rx_done && (state == ST_DATA);
    assign asm_clear = load_start || timeout;
    // Expire only when the terminal count is reached without a fresh strobe.
    assign timeout   = (state != ST_IDLE) && !i_rx_done && (tmo_cnt == '0);

    word_assembler u_asm (
        .clk        (i_clk),
        .reset      (i_reset),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_in    (i_rx_data),
        .word       (word),
        .word_done  (word_done)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state decode and one-cycle control events.
    always_comb begin
        state_next  = state;
        load_start  = 1'b0;
        load_ok     = 1'b0;
        load_fail   = 1'b0;
        set_mode    = 1'b0;
        mode_val    = 1'b0;
        step_req    = 1'b0;
        bad_cmd     = 1'b0;
        cnt_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            load_start = 1'b1;
                            state_next = ST_CNT_HI;
                        end
                        CMD_CONT: begin
                            set_mode = 1'b1;
                            mode_val = 1'b0;
                        end
                        CMD_STEP_MODE: begin
                            set_mode = 1'b1;
                            mode_val = 1'b1;
                        end
                        CMD_STEP: step_req = o_exec_mode;
                        default:  bad_cmd  = 1'b1;
                    endcase
                end
            end
            ST_CNT_HI: begin
                if (i_rx_done) state_next = ST_CNT_LO;
            end
            ST_CNT_LO: begin
                if (i_rx_done) begin
                    cnt_capture = 1'b1;
                    if (32'(count_n) > WORD_LIMIT) begin
                        load_fail  = 1'b1;
                        state_next = ST_IDLE;
                    end else if (count_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = ST_CHK;
`else
                        load_ok    = 1'b1;
                        state_next = ST_IDLE;
`endif
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done && (words_left == 16'd1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_next = ST_CHK;
`else
                    load_ok    = 1'b1;
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (i_rx_done) begin
                    if (i_rx_data == xor_acc) load_ok   = 1'b1;
                    else                      load_fail = 1'b1;
                    state_next = ST_IDLE;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
        if (timeout) begin
            load_fail  = 1'b1;
            state_next = ST_IDLE;
        end
    end

    // Inter-byte timeout down-counter, reloaded on every strobe and while idle.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_rx_done || (state == ST_IDLE)) tmo_cnt <= TMO_LOAD;
        else if (tmo_cnt != '0)                          tmo_cnt <= tmo_cnt - 1'b1;
    end

    // Load bookkeeping: count capture, remaining words, write index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_hi     <= '0;
            words_left <= '0;
            wr_idx     <= '0;
        end else begin
            if (load_start) wr_idx <= '0;
            else if (word_done) wr_idx <= wr_idx + 1'b1;
            if (state == ST_CNT_HI && i_rx_done) cnt_hi <= i_rx_data;
            if (cnt_capture) words_left <= count_n;
            else if (word_done) words_left <= words_left - 16'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of every data byte in the current load.
    always_ff @(posedge i_clk) begin
        if (i_reset || load_start) xor_acc <= '0;
        else if (asm_valid)        xor_acc <= xor_acc ^ i_rx_data;
    end
`endif

    // Registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_imem_we   <= 1'b0;
            o_imem_addr <= '0;
            o_imem_data <= '0;
            o_exec_mode <= 1'b0;
            o_step      <= 1'b0;
            o_busy      <= 1'b0;
            o_load_done <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_imem_we <= word_done;
            o_step    <= step_req;
            if (word_done) begin
                o_imem_addr <= wr_idx;
                o_imem_data <= word;
            end
            if (load_start) begin
                o_load_done <= 1'b0;
                o_error     <= 1'b0;
                o_busy      <= 1'b1;
            end
            if (load_ok) begin
                o_load_done <= 1'b1;
                o_busy      <= 1'b0;
            end
            if (load_fail) begin
                o_error <= 1'b1;
                o_busy  <= 1'b0;
            end
            if (set_mode) begin
                o_exec_mode <= mode_val;
                o_error     <= 1'b0;
            end
            if (bad_cmd) o_error <= 1'b1;
        end
    end

endmodule

// File: doc/interface_loader.md
INTERFACE_LOADER -- requirements
Module: interface_loader

Interface
REQ-001 Parameter IMEM_ADDR_W, default 8: instruction-memory word-address width; capacity is 2^IMEM_ADDR_W words.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: idle cycles allowed between bytes inside a load before the load is aborted.
REQ-003 i_clk  in  1  single clock; every flop on the rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_rx_data  in  8  byte from the UART receiver.
REQ-006 i_rx_done  in  1  one-cycle strobe; i_rx_data is valid in the same cycle.
REQ-007 o_imem_we  out  1  one-cycle instruction-memory write strobe.
REQ-008 o_imem_addr  out  IMEM_ADDR_W  word address for the write.
REQ-009 o_imem_data  out  32  instruction word for the write.
REQ-010 o_exec_mode  out  1  0 = continuous, 1 = step.
REQ-011 o_step  out  1  one-cycle step pulse to the pipeline.
REQ-012 o_busy  out  1  high while a load is in progress.
REQ-013 o_load_done  out  1  level; last load completed successfully.
REQ-014 o_error  out  1  sticky protocol-error flag.

Function
REQ-015 Command bytes accepted only in IDLE: 0x4C 'L' = load, 0x43 'C' = continuous mode, 0x53 'S' = step mode, 0x4E 'N' = step.
REQ-016 FSM states: IDLE, CNT_HI, CNT_LO, DATA, CHK; one transition at most per i_rx_done strobe, except timeout.
REQ-017 'L': clear o_load_done and o_error, raise o_busy, go to CNT_HI.
REQ-018 CNT_HI then CNT_LO capture a 16-bit word count N, MSB first.
REQ-019 N > 2^IMEM_ADDR_W: set o_error, drop o_busy, return to IDLE, write nothing.
REQ-020 N = 0: go directly to end-of-load handling (REQ-024).
REQ-021 DATA: bytes are shifted in MSB first; every 4th byte completes one word.
REQ-022 Word write: o_imem_we pulses exactly one cycle, in the cycle after the i_rx_done of the word's 4th byte. o_imem_addr and o_imem_data are valid in that same cycle.
REQ-023 Word addresses start at 0 and increment by 1 per word; with the N limit of REQ-019 the address never wraps.
REQ-024 After word N: load succeeds (o_load_done = 1, o_busy = 0, go to IDLE), or go to CHK when CHECKSUM_EN is defined.
REQ-025 Inside a load, every byte is data; command codes are not decoded.
REQ-026 Timeout: in CNT_HI, CNT_LO, DATA or CHK, TIMEOUT_CYCLES cycles with no i_rx_done causes: o_error = 1, o_busy = 0, return to IDLE, and discard any partial word. The counter clears on every strobe.
REQ-027 'C' sets o_exec_mode = 0. 'S' sets o_exec_mode = 1. Both clear o_error.
REQ-028 'N' pulses o_step for one cycle, in the cycle after the strobe, only when o_exec_mode = 1; otherwise it is ignored.
REQ-029 An unknown byte in IDLE sets o_error and leaves the state unchanged.
REQ-030 All outputs are registered; there are no combinational paths from input to output.

Reset
REQ-031 Reset clears the following outputs to 0: o_imem_we, o_imem_addr, o_imem_data, o_exec_mode, o_step, o_busy, o_load_done, o_error.
REQ-032 Reset forces IDLE and clears the counters and the partial word.
REQ-033 Reset during a load aborts it with no further writes; words already written are not retracted.

Configuration
REQ-034 Macro LOADER_CHECKSUM_EN, when defined: after word N one extra byte is received in CHK and compared with the XOR of all 4N data bytes (0x00 for N = 0).
REQ-035 Checksum match: o_load_done = 1. Mismatch: o_error = 1 and o_load_done stays 0. Either way the block returns to IDLE with o_busy = 0.
REQ-036 Macro undefined: the CHK state and the XOR register are absent, and the load ends after word N.

Structure
REQ-037 Shared package mips_debug_pkg holds: the command-code constants (0x4C, 0x43, 0x53, 0x4E), the FSM state typedef, and the default IMEM_ADDR_W.
REQ-038 One sub-module, word_assembler: shift register plus byte counter (0-3) with a word-complete strobe. Everything else is inline.

Verification
REQ-039 Send 'L', 0x00, 0x02, then bytes 11 22 33 44 AA BB CC DD -> two writes: addr 0 = 0x11223344, addr 1 = 0xAABBCCDD; then o_load_done = 1 and o_busy = 0.
REQ-040 Send 'L', 0x01, 0x01 (N = 257, with IMEM_ADDR_W = 8) -> o_error = 1, no o_imem_we, back in IDLE.
REQ-041 Send 'L', 0x00, 0x01, 0x12, then wait TIMEOUT_CYCLES with no bytes -> o_error = 1, no write; a following 'S' clears o_error.
REQ-042 Send 'N' with o_exec_mode = 0 -> no o_step. Send 'S' then 'N' -> exactly one o_step pulse, one cycle after the strobe.
REQ-043 With LOADER_CHECKSUM_EN: load of 01 02 03 04 followed by checksum 0x04 -> o_load_done = 1; the same load with checksum 0x05 -> o_error = 1 and o_load_done = 0.
REQ-044 Assert i_reset after 6 data bytes of an N = 2 load -> exactly one write (addr 0) occurs, all outputs return to 0, and the next 'L' works normally.
